// File: rtl/if1_defs.sv
// Shared fetch-front-end definitions.
// State encoding, default reset vector and fetch alignment.
package if1_defs;

    localparam int          DEFAULT_ALIGN_BITS = 2;
    localparam logic [31:0] DEFAULT_RESET_VEC  = 32'hE000_0000;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/if1_pcgen.sv
// Fetch-address generator: sequential PCs over valid/ready,
// with redirect, halt, epoch tagging and misalignment flag.
module if1_pcgen
    import if1_defs::*;
#(
    parameter int          VA_WIDTH   = 32,
    parameter int          TAG_WIDTH  = 10,
    parameter int          ALIGN_BITS = DEFAULT_ALIGN_BITS,
    parameter logic [31:0] RESET_VEC  = DEFAULT_RESET_VEC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 redirect_valid_in,
    input  logic [VA_WIDTH-1:0]  redirect_pc_in,
    input  logic                 halt_in,
    input  logic                 ready_in,
    output logic                 valid_out,
    output logic [VA_WIDTH-1:0]  pc_out,
    output logic [TAG_WIDTH-1:0] tag_out,
    output logic                 epoch_out,
    output logic                 misalign_out,
    output logic                 idle_out
);

    localparam logic [VA_WIDTH-1:0] RST_PC = VA_WIDTH'(RESET_VEC);
    localparam logic [VA_WIDTH-1:0] INC    = VA_WIDTH'(1) << ALIGN_BITS;
    localparam logic [VA_WIDTH-1:0] AMASK  = INC - VA_WIDTH'(1);

    logic [1:0]           state_q, state_d;
    logic [VA_WIDTH-1:0]  pc_q, pc_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic                 epoch_q, epoch_d;
    logic                 mis_q, mis_d;
    logic                 hpend_q, hpend_d;
    logic                 xfer;

    assign xfer = (state_q == ST_RUN) && ready_in;

    // Next-state: redirect first, then halt/advance per state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        epoch_d = epoch_q;
        mis_d   = mis_q;
        hpend_d = hpend_q;
        if (redirect_valid_in) begin
            pc_d    = redirect_pc_in;
            epoch_d = ~epoch_q;
            state_d = ST_RUN;
            mis_d   = |(redirect_pc_in & AMASK);
            hpend_d = 1'b0;
            if (xfer) begin
                tag_d = tag_q + TAG_WIDTH'(1);
            end
        end else begin
            if (halt_in) begin
                hpend_d = 1'b1;
            end
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (xfer) begin
                        tag_d = tag_q + TAG_WIDTH'(1);
                        if (mis_q) begin
                            state_d = ST_HALTED;
                        end else begin
                            pc_d = pc_q + INC;
                            if (hpend_q || halt_in) begin
                                state_d = ST_HALTED;
                                hpend_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= RST_PC;
            tag_q   <= '0;
            epoch_q <= 1'b0;
            mis_q   <= 1'b0;
            hpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            epoch_q <= epoch_d;
            mis_q   <= mis_d;
            hpend_q <= hpend_d;
        end
    end

    assign valid_out    = (state_q == ST_RUN);
    assign idle_out     = (state_q == ST_HALTED);
    assign pc_out       = pc_q;
    assign tag_out      = tag_q;
    assign epoch_out    = epoch_q;
    assign misalign_out = mis_q;

endmodule

// File: doc/if1_pcgen.md
# if1_pcgen

Parametrised fetch-address generator for the ECO32 instruction-fetch front end, replacing the fixed if1a/if1b address pair. It emits a stream of sequential virtual fetch addresses over a valid/ready handshake to the next fetch stage. Generalisations: configurable address width, stride, tag width and reset vector. New behaviour: redirect (branch/exception target), halt, epoch tagging of redirected streams, and misaligned-target detection.

## Interface
- `VA_WIDTH`, 32: virtual address width.
- `TAG_WIDTH`, 10: width of the per-address sequence tag.
- `ALIGN_BITS`, 2: log2 of the fetch stride; stride INC = 2**ALIGN_BITS.
- `RESET_VEC`, 32'hE000_0000: first fetch address after reset, truncated to VA_WIDTH. Low ALIGN_BITS must be zero.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low (asserted when 0).
- `redirect_valid_in`  in  1  load a new fetch target this cycle.
- `redirect_pc_in`  in  VA_WIDTH  redirect target.
- `halt_in`  in  1  stop issuing after the current address transfers.
- `ready_in`  in  1  downstream accepts the output this cycle.
- `valid_out`  out  1  output address valid.
- `pc_out`  out  VA_WIDTH  fetch virtual address.
- `tag_out`  out  TAG_WIDTH  sequence number of this address.
- `epoch_out`  out  1  stream epoch; toggles on every redirect.
- `misalign_out`  out  1  pc_out has non-zero low ALIGN_BITS.
- `idle_out`  out  1  block is in HALTED.

## Operation
- Transfer: `valid_out & ready_in` at a clock edge.
- States:
  - BOOT: entered on reset; `valid_out`=0.
  - RUN: `valid_out`=1.
  - HALTED: `valid_out`=0, `idle_out`=1.
- Reset values: state BOOT, `valid_out`=0, `pc_out`=RESET_VEC, `tag_out`=0, `epoch_out`=0, `misalign_out`=0, `idle_out`=0.
- BOOT -> RUN unconditionally on the first edge with `rst`=1. The first output is RESET_VEC, tag 0.
- RUN with transfer and no redirect/halt:
  - `pc_out` <= `pc_out` + INC, modulo 2**VA_WIDTH (wraps silently).
  - `tag_out` <= `tag_out` + 1, modulo 2**TAG_WIDTH.
- RUN without transfer: all outputs hold, stable until transfer or redirect.
- Redirect (any state, highest priority):
  - `pc_out` <= `redirect_pc_in`; `epoch_out` toggles; state <= RUN; `valid_out` <= 1.
  - `misalign_out` <= OR of `redirect_pc_in`[ALIGN_BITS-1:0].
  - `tag_out` increments only if a transfer occurred in the same cycle. The old output counts as delivered.
  - An untransferred pending output is discarded. It may therefore change while valid; downstream relies on `epoch_out` to drop stale work.
- Halt (no redirect this cycle): sets an internal halt-pending flag.
  - Pending and transfer happens: state <= HALTED, tag increments, `pc_out` holds the next sequential address.
  - Halt asserted in HALTED or BOOT: flag set, no effect until RUN. BOOT->RUN then halts after the first transfer.
  - Redirect clears the flag.
- Misaligned entry: emitted once with `misalign_out`=1. On its transfer, state <= HALTED; it never increments past a misaligned pc. Only a redirect leaves HALTED.
- Redirect and halt in the same cycle: redirect wins; halt is ignored.
- Reset mid-operation: all state returns to reset values on the next edge. Pending outputs and flags are lost.

## Timing
- Latency: reset release -> first `valid_out` = 1 cycle; redirect -> new `pc_out` = 1 cycle; transfer -> next address = 1 cycle.
- Sustained throughput: one address per cycle while `ready_in`=1.
- All outputs are registered. No combinational path from any input to any output, including `ready_in`.

## Structure
- Shared package/header `if1_defs`:
  - state encoding (BOOT/RUN/HALTED);
  - default RESET_VEC;
  - ALIGN_BITS default, shared with later fetch stages.
- Single module, no sub-modules. The incrementer and tag counter are inline; a separate module is not justified.

## Test plan
- Reset and boot: hold `rst`=0 3 cycles, then `ready_in`=1 for 4 cycles -> valid from cycle 1; pc E0000000, E0000004, E0000008, E000000C; tags 0-3; epoch 0.
- Backpressure: `ready_in`=0 for 5 cycles at pc E0000008 -> pc, tag and valid stable. Release -> E000000C next cycle.
- Redirect with transfer: redirect to 00004038 while pc E0000004 (tag 1) transfers -> next pc 00004038, tag 2, epoch 1. Continues 0000403C, 00004040.
- Redirect without transfer, plus misalignment: `ready_in`=0, redirect to 0000603E -> pc 0000603E, `misalign_out`=1, tag unchanged. After transfer -> HALTED, `valid_out`=0, `idle_out`=1.
- Halt, then redirect+halt priority: halt at pc E0000010 -> HALTED after its transfer, `pc_out` E0000014. Redirect to 00001000 with `halt_in`=1 -> RUN at 00001000, epoch toggled.
- Wrap with small parameters: VA_WIDTH=8, TAG_WIDTH=2, RESET_VEC 8'hF8 -> pc F8, FC, 00, 04; tags 0, 1, 2, 3, 0.
